pixel_readout_ctrl: RTL and testbench
=====================================

Name: pixel_readout_ctrl

Overview:
Acquisition and readout sequencer for one column chain of digit_front_end pixels. It clears the pixel LFSR counters, opens shutterA/shutterB together for a programmed exposure, then serially shifts both counter chains out. It deserialises the SerOutA/SerOutB bit streams into per-pixel word pairs and hands them off over a valid/ready interface, either single-shot or continuously.

Parameters:
N_PIX, 16, number of pixels daisy-chained on SerInA/SerOutA and SerInB/SerOutB
CNT_W, 8, bits per pixel counter (LFSR width)
SHUT_W, 16, width of exposure-time field
IDX_W, $clog2(N_PIX), width of pixIdx

Ports:
clk_read  in  1  single block clock, shared with pixel counters
reset  in  1  synchronous, active-high reset
start  in  1  level/pulse; begins a frame when sampled high in IDLE
continuous  in  1  1 = re-arm automatically after each frame
abort  in  1  returns to IDLE at next edge from any state
shutterTime  in  SHUT_W  exposure length in clk_read cycles (0 treated as 1)
busy  out  1  high in every state except IDLE
cntReset  out  1  counter clear strobe to pixels
shutterA  out  1  shutter to counter A chain
shutterB  out  1  shutter to counter B chain
shiftEn  out  1  chain shift enable; shutters are low whenever high
SerInA  out  1  chain A serial input, constant 0
SerInB  out  1  chain B serial input, constant 0
SerOutA  in  1  chain A serial output (last pixel)
SerOutB  in  1  chain B serial output (last pixel)
dataA  out  CNT_W  chain A word for pixIdx
dataB  out  CNT_W  chain B word for pixIdx
pixIdx  out  IDX_W  chain position, 0 = pixel nearest SerOut
dataValid  out  1  word pair valid
dataReady  in  1  consumer accepts when dataValid & dataReady
frameDone  out  1  one-cycle pulse on acceptance of last word pair

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters and shift registers 0.
- States: IDLE, CLEAR, EXPOSE, SETTLE, SHIFT, PRESENT.
- IDLE: start=1 -> CLEAR. start is ignored outside IDLE.
- CLEAR: exactly 1 cycle with cntReset=1 -> EXPOSE. shutterTime is latched here.
- EXPOSE: shutterA=shutterB=1 for max(shutterTime,1) cycles, counted from the first EXPOSE cycle -> SETTLE.
- SETTLE: 2 cycles with shutters low and shiftEn=0, so the last hit pulses can land -> SHIFT with pixIdx=0.
- SHIFT: shiftEn=1 for exactly CNT_W cycles. Each of those edges captures shA<={shA[CNT_W-2:0],SerOutA}, and likewise for B, so the first bit is the MSB. Then -> PRESENT.
- PRESENT: shiftEn=0; dataValid=1; dataA/dataB/pixIdx held stable until the handshake.
  - On accept with pixIdx<N_PIX-1: pixIdx++ -> SHIFT.
  - On accept with pixIdx=N_PIX-1: frameDone=1 for 1 cycle; continuous=1 -> CLEAR, else -> IDLE.
- Backpressure: chain shifting stalls fully while dataReady=0; no bits are lost.
- Zero-wait frame length with dataReady tied high: 1 + max(T,1) + 2 + N_PIX*(CNT_W+1) cycles from CLEAR entry to return.
- continuous is sampled only at the final accept.
- abort has priority over all transitions. Next edge: IDLE, shutters/shiftEn/dataValid/cntReset=0, frameDone not pulsed. Partially shifted chain contents are discarded; the next frame's CLEAR re-zeroes the counters.
- reset mid-frame: identical to the abort outcome, plus all registers zeroed.
- Invariants: shutter(A|B) & shiftEn never both 1; cntReset never coincides with shutter or shiftEn; dataValid never drops without a handshake, except on abort or reset.

Test Plan:
1. Single shot, N_PIX=4, CNT_W=8, shutterTime=5, dataReady=1. Chain model preloaded A=0xA5,0x3C,0xFF,0x01 and B=0x00,0x80,0x7E,0x55 (pos 0..3). Required: cntReset one cycle; shutters high 5 cycles; 4 accepts in pixIdx order 0..3 with matching words; frameDone at last accept; busy low after. Total 44 cycles.
2. shutterTime=0 -> shutters high exactly 1 cycle; frame otherwise as in 1.
3. Backpressure: dataReady low 7 cycles at pixIdx=1. Required: shiftEn stays 0 and dataA/dataB/pixIdx stay stable throughout; words still exact; frame lengthened by exactly 7 cycles.
4. continuous=1 for 2 frames, then cleared during frame 2. Required: CLEAR follows the frame-1 last accept on the next cycle; 2 frameDone pulses; IDLE after frame 2; start pulses during busy have no effect.
5. abort asserted in EXPOSE cycle 3, and separately in SHIFT bit 4 of pixIdx 2. Required: next cycle IDLE with all outputs 0 and no frameDone. A following start gives a correct full frame.
6. Synchronous reset asserted in PRESENT with dataValid=1. Required: next edge all outputs 0; the shutter & shiftEn invariant assertion holds for the whole run.

Source files
------------

// File: rtl/pixel_readout_ctrl.sv
// Acquisition/readout sequencer for one pixel column chain: clear, expose, settle,
// then shift both counter chains out and present per-pixel word pairs over valid/ready.
module pixel_readout_ctrl #(
  parameter int N_PIX  = 16,
  parameter int CNT_W  = 8,
  parameter int SHUT_W = 16,
  parameter int IDX_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic              clk_read,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [SHUT_W-1:0] shutterTime,
  output logic              busy,
  output logic              cntReset,
  output logic              shutterA,
  output logic              shutterB,
  output logic              shiftEn,
  output logic              SerInA,
  output logic              SerInB,
  input  logic              SerOutA,
  input  logic              SerOutB,
  output logic [CNT_W-1:0]  dataA,
  output logic [CNT_W-1:0]  dataB,
  output logic [IDX_W-1:0]  pixIdx,
  output logic              dataValid,
  input  logic              dataReady,
  output logic              frameDone
);

  localparam int BIT_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_EXPOSE, S_SETTLE, S_SHIFT, S_PRESENT
  } state_t;

  state_t state_q, state_d;
  // Shared down-counter: exposure length, then the settle gap.
  logic [SHUT_W-1:0] time_q, time_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [IDX_W-1:0]  pix_q, pix_d;
  logic [CNT_W-1:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic busy_q, busy_d, cnt_reset_q, cnt_reset_d, shutter_q, shutter_d;
  logic shift_en_q, shift_en_d, data_valid_q, data_valid_d, frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    time_d       = time_q;
    bit_d        = bit_q;
    pix_d        = pix_q;
    sh_a_d       = sh_a_q;
    sh_b_d       = sh_b_q;
    frame_done_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      time_d  = '0;
      bit_d   = '0;
      pix_d   = '0;
      sh_a_d  = '0;
      sh_b_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = S_CLEAR;
        S_CLEAR: begin
          state_d = S_EXPOSE;
          time_d  = (shutterTime == '0) ? '0 : shutterTime - SHUT_W'(1);
        end
        S_EXPOSE: begin
          if (time_q == '0) begin
            state_d = S_SETTLE;
            time_d  = SHUT_W'(1);
          end else begin
            time_d = time_q - SHUT_W'(1);
          end
        end
        S_SETTLE: begin
          if (time_q == '0) begin
            state_d = S_SHIFT;
            bit_d   = LAST_BIT;
            pix_d   = '0;
          end else begin
            time_d = time_q - SHUT_W'(1);
          end
        end
        S_SHIFT: begin
          // First bit out of the chain is the MSB of the nearest pixel.
          sh_a_d = CNT_W'({sh_a_q, SerOutA});
          sh_b_d = CNT_W'({sh_b_q, SerOutB});
          if (bit_q == '0) state_d = S_PRESENT;
          else bit_d = bit_q - BIT_W'(1);
        end
        S_PRESENT: begin
          if (dataReady) begin
            if (pix_q == LAST_IDX) begin
              frame_done_d = 1'b1;
              pix_d        = '0;
              sh_a_d       = '0;
              sh_b_d       = '0;
              state_d      = continuous ? S_CLEAR : S_IDLE;
            end else begin
              pix_d   = pix_q + IDX_W'(1);
              bit_d   = LAST_BIT;
              state_d = S_SHIFT;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d       = (state_d != S_IDLE);
    cnt_reset_d  = (state_d == S_CLEAR);
    shutter_d    = (state_d == S_EXPOSE);
    shift_en_d   = (state_d == S_SHIFT);
    data_valid_d = (state_d == S_PRESENT);
  end

  always_ff @(posedge clk_read) begin
    if (reset) begin
      state_q      <= S_IDLE;
      time_q       <= '0;
      bit_q        <= '0;
      pix_q        <= '0;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      busy_q       <= 1'b0;
      cnt_reset_q  <= 1'b0;
      shutter_q    <= 1'b0;
      shift_en_q   <= 1'b0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      bit_q        <= bit_d;
      pix_q        <= pix_d;
      sh_a_q       <= sh_a_d;
      sh_b_q       <= sh_b_d;
      busy_q       <= busy_d;
      cnt_reset_q  <= cnt_reset_d;
      shutter_q    <= shutter_d;
      shift_en_q   <= shift_en_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy      = busy_q;
  assign cntReset  = cnt_reset_q;
  assign shutterA  = shutter_q;
  assign shutterB  = shutter_q;
  assign shiftEn   = shift_en_q;
  assign dataValid = data_valid_q;
  assign frameDone = frame_done_q;
  assign dataA     = sh_a_q;
  assign dataB     = sh_b_q;
  assign pixIdx    = pix_q;
  assign SerInA    = 1'b0;
  assign SerInB    = 1'b0;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Scoreboard bench for pixel_readout_ctrl: a pixel-chain model loads known words at each
// clear, and a negedge monitor checks every handshake, frame timing and invariant.
`timescale 1ns/1ps
module tb_pixel_readout_ctrl;
  localparam int N_PIX     = 4;
  localparam int CNT_W     = 8;
  localparam int SHUT_W    = 16;
  localparam int IDX_W     = 2;
  localparam int NBITS     = N_PIX * CNT_W;
  localparam int EXP_DEPTH = 1024;

  logic clk_read = 1'b0;
  logic reset = 1'b1, start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic [SHUT_W-1:0] shutterTime = '0;
  logic busy, cntReset, shutterA, shutterB, shiftEn, SerInA, SerInB;
  logic SerOutA, SerOutB;
  logic [CNT_W-1:0] dataA, dataB;
  logic [IDX_W-1:0] pixIdx;
  logic dataValid, frameDone;
  logic dataReady = 1'b1;

  always #5 clk_read = ~clk_read;

  pixel_readout_ctrl #(.N_PIX(N_PIX), .CNT_W(CNT_W), .SHUT_W(SHUT_W)) dut (
    .clk_read(clk_read), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .shutterTime(shutterTime), .busy(busy), .cntReset(cntReset),
    .shutterA(shutterA), .shutterB(shutterB), .shiftEn(shiftEn), .SerInA(SerInA),
    .SerInB(SerInB), .SerOutA(SerOutA), .SerOutB(SerOutB), .dataA(dataA), .dataB(dataB),
    .pixIdx(pixIdx), .dataValid(dataValid), .dataReady(dataReady), .frameDone(frameDone)
  );

  // Pixel chain model: serial stream ordered position 0 first, each word MSB first.
  logic chain_a [NBITS];
  logic chain_b [NBITS];
  int ptr = NBITS;
  int wr = 0, base = 0;
  logic [CNT_W-1:0] exp_a [EXP_DEPTH];
  logic [CNT_W-1:0] exp_b [EXP_DEPTH];
  int exp_idx [EXP_DEPTH];
  logic [CNT_W-1:0] gen_a, gen_b;
  bit use_preset = 1'b0;
  logic [CNT_W-1:0] preset_a [N_PIX] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
  logic [CNT_W-1:0] preset_b [N_PIX] = '{8'h00, 8'h80, 8'h7E, 8'h55};

  assign SerOutA = (ptr < NBITS) ? chain_a[ptr] : 1'b0;
  assign SerOutB = (ptr < NBITS) ? chain_b[ptr] : 1'b0;

  always @(posedge clk_read) begin
    if (cntReset) begin
      for (int p = 0; p < N_PIX; p++) begin
        gen_a = use_preset ? preset_a[p] : CNT_W'($urandom);
        gen_b = use_preset ? preset_b[p] : CNT_W'($urandom);
        exp_a[(wr + p) % EXP_DEPTH]   <= gen_a;
        exp_b[(wr + p) % EXP_DEPTH]   <= gen_b;
        exp_idx[(wr + p) % EXP_DEPTH] <= p;
        for (int b = 0; b < CNT_W; b++) begin
          chain_a[p * CNT_W + (CNT_W - 1 - b)] <= gen_a[b];
          chain_b[p * CNT_W + (CNT_W - 1 - b)] <= gen_b[b];
        end
      end
      base <= wr;
      wr   <= wr + N_PIX;
      ptr  <= 0;
    end else if (shiftEn) begin
      ptr <= ptr + 1;
    end
  end

  // Stimulus-owned flags read by the monitor.
  int exp_frames = 0;
  bit end_req = 1'b0, timeout_flag = 1'b0;

  // Monitor / scoreboard state.
  int errors = 0, checks = 0, cycles = 0;
  int rd = 0, frames_done = 0;
  int len = 0, shut_cnt = 0, stalls = 0, pops = 0, t_lat = 0, exp_len = 0, t_eff = 0;
  bit prev_kill = 1'b0, prev_stall = 1'b0, in_frame = 1'b0, pending_done = 1'b0, cont_exp = 1'b0;
  logic [CNT_W-1:0] hold_a, hold_b;
  logic [IDX_W-1:0] hold_idx;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic summary;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  always @(negedge clk_read) begin
    cycles++;
    chk(!((shutterA | shutterB) & shiftEn) && !(cntReset & (shutterA | shutterB | shiftEn)) &&
        (shutterA == shutterB) && !SerInA && !SerInB, "invariants(clr,shA,shB,sh,siA,siB)",
        64'({cntReset, shutterA, shutterB, shiftEn, SerInA, SerInB}), 64'(0));
    if (prev_kill) begin
      chk({busy, cntReset, shutterA, shutterB, shiftEn, dataValid, frameDone} == 7'd0,
          "kill_ctrl", 64'({busy, cntReset, shutterA, shutterB, shiftEn, dataValid, frameDone}), 64'(0));
      chk(dataA == '0 && dataB == '0 && pixIdx == '0, "kill_data",
          64'({dataA, dataB, pixIdx}), 64'(0));
      in_frame     = 1'b0;
      pending_done = 1'b0;
    end else begin
      if (prev_stall)
        chk(dataValid && !shiftEn && dataA == hold_a && dataB == hold_b && pixIdx == hold_idx,
            "stall_hold", 64'({dataValid, shiftEn, dataA, dataB, pixIdx}),
            64'({1'b1, 1'b0, hold_a, hold_b, hold_idx}));
      if (pending_done) begin
        chk(frameDone && cntReset == cont_exp && busy == cont_exp, "frame_end(done,clr,busy)",
            64'({frameDone, cntReset, busy}), 64'({1'b1, cont_exp, cont_exp}));
        pending_done = 1'b0;
      end
      if (frameDone) begin
        chk(in_frame, "done_in_frame", 64'(in_frame), 64'(1));
        if (in_frame) begin
          t_eff   = (t_lat == 0) ? 1 : t_lat;
          exp_len = 1 + t_eff + 2 + N_PIX * (CNT_W + 1) + stalls;
          chk(len == exp_len, "frame_len", 64'(len), 64'(exp_len));
          chk(shut_cnt == t_eff, "expose_len", 64'(shut_cnt), 64'(t_eff));
          chk(pops == N_PIX, "words_per_frame", 64'(pops), 64'(N_PIX));
        end
        frames_done++;
        in_frame = 1'b0;
      end
    end
    if (cntReset) begin
      in_frame = 1'b1;
      len      = 1;
      shut_cnt = 0;
      stalls   = 0;
      pops     = 0;
      t_lat    = int'(shutterTime);
    end else if (in_frame && busy) begin
      len++;
      if (shutterA) shut_cnt++;
      if (dataValid && !dataReady) stalls++;
    end
    if (dataValid && dataReady && !abort && !reset) begin
      if (rd < base) rd = base;
      if (rd >= wr) begin
        chk(1'b0, "unexpected_word", 64'(pixIdx), 64'(0));
      end else begin
        chk(int'(pixIdx) == exp_idx[rd % EXP_DEPTH], "pixIdx", 64'(pixIdx), 64'(exp_idx[rd % EXP_DEPTH]));
        chk(dataA == exp_a[rd % EXP_DEPTH], "dataA", 64'(dataA), 64'(exp_a[rd % EXP_DEPTH]));
        chk(dataB == exp_b[rd % EXP_DEPTH], "dataB", 64'(dataB), 64'(exp_b[rd % EXP_DEPTH]));
        if (exp_idx[rd % EXP_DEPTH] == N_PIX - 1) begin
          pending_done = 1'b1;
          cont_exp     = continuous;
        end
        rd++;
        pops++;
      end
    end
    prev_stall = dataValid && !dataReady && !abort && !reset;
    hold_a     = dataA;
    hold_b     = dataB;
    hold_idx   = pixIdx;
    prev_kill  = abort | reset;
    if (end_req) begin
      if (rd < base) rd = base;
      chk(frames_done == exp_frames, "frame_count", 64'(frames_done), 64'(exp_frames));
      chk(rd == wr, "words_drained", 64'(rd), 64'(wr));
      chk(!timeout_flag, "no_timeout", 64'(timeout_flag), 64'(0));
      chk(!busy, "idle_at_end", 64'(busy), 64'(0));
      summary();
    end
    if (cycles > 60000) begin
      chk(1'b0, "global_timeout", 64'(cycles), 64'(60000));
      summary();
    end
  end

  task automatic tick;
    @(posedge clk_read);
    #1;
  endtask

  // mode 0: ready tied high, 1: random ready, 2: ready low 7 cycles at pixIdx 1.
  task automatic run_frame(input int t, input int mode);
    bit stalled;
    stalled     = 1'b0;
    shutterTime = SHUT_W'(t);
    dataReady   = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3000 && busy; c++) begin
      if (mode == 1) begin
        dataReady = ($urandom_range(0, 3) != 0);
      end else if (mode == 2 && !stalled && dataValid && pixIdx == 2'd1) begin
        dataReady = 1'b0;
        repeat (7) tick();
        dataReady = 1'b1;
        stalled   = 1'b1;
      end
      tick();
    end
    if (busy) timeout_flag = 1'b1;
    exp_frames++;
    dataReady = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    use_preset = 1'b1;
    run_frame(5, 0);
    use_preset = 1'b0;
    run_frame(0, 0);
    run_frame(4, 2);

    // Two continuous frames; start pulses while busy must be ignored.
    continuous  = 1'b1;
    shutterTime = SHUT_W'(2);
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 500 && !frameDone; c++) tick();
    if (!frameDone) timeout_flag = 1'b1;
    repeat (3) tick();
    continuous = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 500 && busy; c++) tick();
    if (busy) timeout_flag = 1'b1;
    exp_frames += 2;

    // Abort in the third exposure cycle.
    shutterTime = SHUT_W'(10);
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !shutterA; c++) tick();
    if (!shutterA) timeout_flag = 1'b1;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_frame(3, 1);

    // Abort mid-shift of pixel 2.
    shutterTime = SHUT_W'(2);
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && !(shiftEn && pixIdx == 2'd2); c++) tick();
    if (!(shiftEn && pixIdx == 2'd2)) timeout_flag = 1'b1;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_frame(6, 0);

    // Synchronous reset while a word is being presented.
    dataReady   = 1'b0;
    shutterTime = SHUT_W'(1);
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !dataValid; c++) tick();
    if (!dataValid) timeout_flag = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    dataReady = 1'b1;
    run_frame(2, 1);

    for (int i = 0; i < 10; i++) run_frame(int'($urandom_range(0, 12)), 1);
    repeat (3) tick();
    end_req = 1'b1;
  end
endmodule
